// File: rtl/argmax10_classifier.sv
// ---------------------------------------------------------------------------
// argmax10_classifier
//
// Final stage of the Semeion digit accelerator. It takes the ten signed
// layer-2 neuron outputs and reports the index (0..9) of the largest one
// as the predicted digit.
//
// The ten inputs are captured on a one-cycle start strobe and then scanned
// one value per clock. Ties go to the lowest index because only a strictly
// greater value replaces the running best.
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   reset         asynchronous, active-low reset
//   in_1..in_10   signed neuron values (in_1 = class 0, in_10 = class 9)
//   start         one-cycle strobe, inputs valid in the cycle it is high
//   done          one-cycle pulse, max is valid from this cycle onward
//   max           index of the largest input, 0..9, held between results
// ---------------------------------------------------------------------------
module argmax10_classifier #(
  parameter int LEAKY_LAYER_SIZE = 32,
  parameter int WEIGHT_SIZE      = 8,
  parameter int INPUT_SIZE       = 2 * (LEAKY_LAYER_SIZE + WEIGHT_SIZE) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [INPUT_SIZE-1:0] in_1,
  input  logic signed [INPUT_SIZE-1:0] in_2,
  input  logic signed [INPUT_SIZE-1:0] in_3,
  input  logic signed [INPUT_SIZE-1:0] in_4,
  input  logic signed [INPUT_SIZE-1:0] in_5,
  input  logic signed [INPUT_SIZE-1:0] in_6,
  input  logic signed [INPUT_SIZE-1:0] in_7,
  input  logic signed [INPUT_SIZE-1:0] in_8,
  input  logic signed [INPUT_SIZE-1:0] in_9,
  input  logic signed [INPUT_SIZE-1:0] in_10,
  input  logic                         start,
  output logic                         done,
  output logic [3:0]                   max
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Class 0 seeds the running best directly at the start edge, so only
  // classes 1..9 need to be held for the scan.
  logic signed [INPUT_SIZE-1:0] cap_q [1:9];
  logic signed [INPUT_SIZE-1:0] cap_d [1:9];

  logic signed [INPUT_SIZE-1:0] best_val_q, best_val_d;
  logic [3:0]                   best_idx_q, best_idx_d;
  logic [3:0]                   cnt_q, cnt_d;
  logic [3:0]                   max_q, max_d;
  logic                         done_q, done_d;
  logic signed [INPUT_SIZE-1:0] cur_val;

  // Selects the captured value for the class currently being scanned.
  // An explicit case keeps the read bounded to the stored classes 1..9.
  always_comb begin
    cur_val = '0;
    case (cnt_q)
      4'd1:    cur_val = cap_q[1];
      4'd2:    cur_val = cap_q[2];
      4'd3:    cur_val = cap_q[3];
      4'd4:    cur_val = cap_q[4];
      4'd5:    cur_val = cap_q[5];
      4'd6:    cur_val = cap_q[6];
      4'd7:    cur_val = cap_q[7];
      4'd8:    cur_val = cap_q[8];
      4'd9:    cur_val = cap_q[9];
      default: cur_val = '0;
    endcase
  end

  // Next-state and datapath logic. done defaults low so it only pulses
  // for the single FINISH edge; max only moves at FINISH.
  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    cnt_d      = cnt_q;
    max_d      = max_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cap_d[1]   = in_2;
          cap_d[2]   = in_3;
          cap_d[3]   = in_4;
          cap_d[4]   = in_5;
          cap_d[5]   = in_6;
          cap_d[6]   = in_7;
          cap_d[7]   = in_8;
          cap_d[8]   = in_9;
          cap_d[9]   = in_10;
          best_val_d = in_1;
          best_idx_d = 4'd0;
          cnt_d      = 4'd1;
          state_d    = SCAN;
        end
      end

      SCAN: begin
        // Strict compare: equal values keep the earlier (lower) index.
        if (cur_val > best_val_q) begin
          best_val_d = cur_val;
          best_idx_d = cnt_q;
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        max_d   = best_idx_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset aborts any run in progress and clears every
  // stored value, so an interrupted scan never produces a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      best_val_q <= '0;
      best_idx_q <= '0;
      cnt_q      <= '0;
      max_q      <= '0;
      done_q     <= 1'b0;
      for (int i = 1; i <= 9; i++) begin
        cap_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      cnt_q      <= cnt_d;
      max_q      <= max_d;
      done_q     <= done_d;
      for (int i = 1; i <= 9; i++) begin
        cap_q[i] <= cap_d[i];
      end
    end
  end

  assign done = done_q;
  assign max  = max_q;

endmodule

// File: tb/tb_argmax10_classifier.sv
// ---------------------------------------------------------------------------
// tb_argmax10_classifier
//
// Self-checking bench for argmax10_classifier. A table of directed vectors
// with known answers is applied first, followed by hand-written sequences
// for capture, busy-start, result hold and mid-run reset, then randomized
// vectors compared against a plain argmax reference model.
// ---------------------------------------------------------------------------
module tb_argmax10_classifier;

  localparam int W = 81;

  typedef logic [9:0][W-1:0] vec_t;

  typedef struct packed {
    vec_t       vals;
    logic [3:0] expMax;
  } vec_rec_t;

  logic       clk;
  logic       reset;
  logic       start;
  vec_t       tbIn;
  logic       done;
  logic [3:0] max;

  int passCount  = 0;
  int checkCount = 0;

  vec_rec_t table_q [8];

  argmax10_classifier dut (
    .clk   (clk),
    .reset (reset),
    .in_1  (tbIn[0]),
    .in_2  (tbIn[1]),
    .in_3  (tbIn[2]),
    .in_4  (tbIn[3]),
    .in_5  (tbIn[4]),
    .in_6  (tbIn[5]),
    .in_7  (tbIn[6]),
    .in_8  (tbIn[7]),
    .in_9  (tbIn[8]),
    .in_10 (tbIn[9]),
    .start (start),
    .done  (done),
    .max   (max)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: first index holding the largest signed value.
  function automatic int refArgmax(input vec_t v);
    int best = 0;
    for (int i = 1; i < 10; i++) begin
      if ($signed(v[i]) > $signed(v[best])) best = i;
    end
    return best;
  endfunction

  function automatic vec_t fillAll(input logic [W-1:0] val);
    vec_t v;
    for (int i = 0; i < 10; i++) v[i] = val;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Drives a vector with a one-cycle start strobe; returns #1 after the
  // capturing edge, where any previous done pulse must have cleared.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    tbIn  = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("done low after start edge", int'(done), 0);
  endtask

  // Counts clock edges after the start edge until done is seen.
  task automatic waitDone(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic runVector(input string name, input vec_t v, input int expMax);
    int lat;
    applyStimulus(v);
    waitDone(lat);
    checkOutput({name, " latency"}, lat, 10);
    checkOutput({name, " max"}, int'(max), expMax);
  endtask

  function automatic vec_t randomVector();
    vec_t v;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 0)
        v[i] = W'($signed($urandom_range(0, 6)) - 3);
      else
        v[i] = W'({$urandom(), $urandom(), $urandom()});
    end
    return v;
  endfunction

  initial begin
    logic [W-1:0] mostNeg;
    logic [W-1:0] mostPos;
    logic [W-1:0] minusOne;
    vec_t         v;
    vec_t         vB;
    int           lat;
    int           doneCount;
    int           holdErrors;
    int           seenMax;
    int           expMax;

    mostNeg  = {1'b1, {(W-1){1'b0}}};
    mostPos  = {1'b0, {(W-1){1'b1}}};
    minusOne = '1;

    // Directed vectors with known answers.
    for (int i = 0; i < 10; i++) table_q[0].vals[i] = W'(10 * (i + 1));
    table_q[0].expMax = 4'd9;
    table_q[1].vals = fillAll(W'(1));
    table_q[1].vals[4] = W'(500);
    table_q[1].expMax = 4'd4;
    table_q[2].vals = fillAll(minusOne);
    table_q[2].vals[2] = W'(-5);
    table_q[2].vals[7] = W'(0);
    table_q[2].expMax = 4'd7;
    for (int i = 0; i < 10; i++) table_q[3].vals[i] = W'(-10 - i);
    table_q[3].vals[5] = W'(-2);
    table_q[3].expMax = 4'd5;
    table_q[4].vals = fillAll(mostNeg);
    table_q[4].vals[1] = mostPos;
    table_q[4].expMax = 4'd1;
    table_q[5].vals = fillAll(W'(7));
    table_q[5].expMax = 4'd0;
    table_q[6].vals = fillAll(W'(0));
    table_q[6].vals[3] = W'(50);
    table_q[6].vals[8] = W'(50);
    table_q[6].expMax = 4'd3;
    table_q[7].vals = fillAll(mostNeg);
    table_q[7].vals[1] = minusOne;
    table_q[7].vals[2] = W'(0);
    table_q[7].expMax = 4'd2;

    // Reset held for three cycles, then idle without start.
    reset = 1'b0;
    start = 1'b0;
    tbIn  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset max", int'(max), 0);
    @(negedge clk);
    reset = 1'b1;
    doneCount = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) doneCount++;
    end
    checkOutput("no done without start", doneCount, 0);

    // Table vectors, back to back; each start lands on the edge after done.
    for (int t = 0; t < 8; t++) begin
      runVector($sformatf("table[%0d]", t), table_q[t].vals, int'(table_q[t].expMax));
    end

    // Inputs change one cycle after start: result follows the captured set.
    v = fillAll(W'(3));
    v[9] = W'(900);
    vB = fillAll(W'(0));
    vB[0] = W'(5000);
    applyStimulus(v);
    @(negedge clk);
    tbIn = vB;
    waitDone(lat);
    checkOutput("capture latency", lat, 10);
    checkOutput("capture max", int'(max), 9);

    // Start re-pulsed mid-scan must be ignored: one done, original answer.
    v = fillAll(W'(-4));
    v[6] = W'(12);
    applyStimulus(v);
    doneCount = 0;
    lat = -1;
    seenMax = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 4) begin
        tbIn  = vB;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        doneCount++;
        if (doneCount == 1) begin
          lat = k;
          seenMax = int'(max);
        end
      end
    end
    checkOutput("busy done count", doneCount, 1);
    checkOutput("busy latency", lat, 10);
    checkOutput("busy max", seenMax, 6);

    // max holds for 20 idle cycles while the inputs wander.
    holdErrors = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      tbIn = randomVector();
      @(posedge clk);
      #1;
      if (max !== 4'd6 || done !== 1'b0) holdErrors++;
    end
    checkOutput("hold cycles with changed max/done", holdErrors, 0);

    // Reset five cycles into a scan: outputs clear at once, no done later.
    applyStimulus(table_q[0].vals);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid-run reset max", int'(max), 0);
    checkOutput("mid-run reset done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    doneCount = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) doneCount++;
    end
    checkOutput("no done after aborted run", doneCount, 0);
    runVector("after reset", table_q[1].vals, 4);

    // Randomized vectors against the reference model.
    for (int r = 0; r < 30; r++) begin
      v = randomVector();
      expMax = refArgmax(v);
      runVector($sformatf("random[%0d]", r), v, expMax);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Safety net in case the stimulus process stalls.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
